router_input_requester: RTL and testbench

- Requester side of the router's weak round-robin output arbiter: per-input-port flit buffering plus request/grant handshake.
- Buffers incoming wormhole flits per input port and latches the destination output port from each head flit.
- Drives the arbiter's requests/req_ports buses, consumes its registered grants, and forwards granted flits to the crossbar.
- Sits between the link receivers and arbiter + crossbar in every router.

---
 rtl/router_input_requester_if.sv | 23 ++
 rtl/router_input_requester.sv | 72 +++++++
 tb/tb_router_input_requester.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/router_input_requester_if.sv
// router_input_requester_if: flit, request and grant buses between link receivers, requester, arbiter and crossbar.
// REQ_STARVE_CNT_EN adds the per-port starve flags.
interface router_input_requester_if #(
  parameter int IN_PORTS      = 5,
  parameter int OUT_PORT_BITS = 3,
  parameter int FLIT_WIDTH    = 32
);
  logic [IN_PORTS-1:0]               in_valid, in_ready, requests, grants, out_valid;
  logic [IN_PORTS*FLIT_WIDTH-1:0]    in_data, out_data;
  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports, out_port;
`ifdef REQ_STARVE_CNT_EN
  logic [IN_PORTS-1:0]               starve;
  modport slave (input in_valid, in_data, grants,
                 output in_ready, requests, req_ports, out_valid, out_data, out_port, starve);
  modport master (output in_valid, in_data, grants,
                  input in_ready, requests, req_ports, out_valid, out_data, out_port, starve);
`else
  modport slave (input in_valid, in_data, grants,
                 output in_ready, requests, req_ports, out_valid, out_data, out_port);
  modport master (output in_valid, in_data, grants,
                  input in_ready, requests, req_ports, out_valid, out_data, out_port);
`endif
endinterface

// File: rtl/router_input_requester.sv
// router_input_requester: per-port wormhole flit FIFOs with request/grant handshake toward the output arbiter.
// Define REQ_STARVE_CNT_EN for per-port saturating starvation counters and starve flags.
module router_input_requester #(
  parameter int IN_PORTS      = 5,
  parameter int OUT_PORT_BITS = 3,
  parameter int FLIT_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int PTR_BITS      = $clog2(FIFO_DEPTH)
) (
  input logic clk,
  input logic reset,
  router_input_requester_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_e;
  localparam logic [PTR_BITS:0] DEPTH = (PTR_BITS+1)'(FIFO_DEPTH);
  for (genvar g = 0; g < IN_PORTS; g++) begin : g_port
    logic [FLIT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [FLIT_WIDTH-1:0]    front;
    logic [PTR_BITS-1:0]      wr_q, rd_q;
    logic [PTR_BITS:0]        cnt_q, cnt_d;
    logic [OUT_PORT_BITS-1:0] route_q;
    state_e                   state_q;
    logic                     outst_q, ready, wr, fire, drop, pop, req, head, tail;
    assign front = mem_q[rd_q];
    assign head  = front[FLIT_WIDTH-1];
    assign tail  = front[FLIT_WIDTH-2];
    assign ready = cnt_q < DEPTH;
    assign wr    = bus.in_valid[g] & ready;
    assign fire  = bus.grants[g] & outst_q & (state_q == ACTIVE);
    assign drop  = (state_q == IDLE) & (cnt_q != '0) & ~head;
    assign pop   = fire | drop;
    // counting the outstanding flit keeps every grant backed by a buffered flit and stops requests past the tail
    assign req   = (state_q == ACTIVE) & (cnt_q > {{PTR_BITS{1'b0}}, outst_q}) & ~(outst_q & tail);
    assign cnt_d = cnt_q + (PTR_BITS+1)'(wr) - (PTR_BITS+1)'(pop);
    assign bus.in_ready[g]  = ready;
    assign bus.requests[g]  = req;
    assign bus.out_valid[g] = fire;
    assign bus.req_ports[g*OUT_PORT_BITS +: OUT_PORT_BITS] = route_q;
    assign bus.out_port[g*OUT_PORT_BITS +: OUT_PORT_BITS]  = fire ? route_q : '0;
    assign bus.out_data[g*FLIT_WIDTH +: FLIT_WIDTH]        = fire ? front : '0;
    always_ff @(posedge clk)
      if (wr) mem_q[wr_q] <= bus.in_data[g*FLIT_WIDTH +: FLIT_WIDTH];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_q    <= '0;
        rd_q    <= '0;
        cnt_q   <= '0;
        outst_q <= 1'b0;
        route_q <= '0;
        state_q <= IDLE;
      end else begin
        wr_q    <= wr_q + PTR_BITS'(wr);
        rd_q    <= rd_q + PTR_BITS'(pop);
        cnt_q   <= cnt_d;
        outst_q <= req;
        state_q <= state_q == IDLE  ? ((cnt_q != '0 && head) ? ROUTE : IDLE) :
                   state_q == ROUTE ? ACTIVE :
                   (fire && tail)   ? IDLE : ACTIVE;
        if (state_q == ROUTE) route_q <= front[FLIT_WIDTH-3 -: OUT_PORT_BITS];
      end
    end
`ifdef REQ_STARVE_CNT_EN
    logic [7:0] stv_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) stv_q <= '0;
      else stv_q <= (bus.grants[g] || state_q != ACTIVE) ? 8'd0 :
                    (req && stv_q != 8'hff)              ? stv_q + 8'd1 : stv_q;
    end
    assign bus.starve[g] = &stv_q;
`endif
  end
endmodule

// File: tb/tb_router_input_requester.sv
// tb_router_input_requester: directed vectors with hand-computed expectations for router_input_requester.
module tb_router_input_requester;
  localparam int N = 5, OB = 3, FW = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0, n_fail = 0;
  router_input_requester_if #(.IN_PORTS(N), .OUT_PORT_BITS(OB), .FLIT_WIDTH(FW)) bus ();
  router_input_requester #(.IN_PORTS(N), .OUT_PORT_BITS(OB), .FLIT_WIDTH(FW), .FIFO_DEPTH(4), .PTR_BITS(2))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    bus.in_valid = '0;
  endtask
  task automatic put(input int p, input logic [FW-1:0] f);
    bus.in_valid[p] = 1'b1;
    bus.in_data[p*FW +: FW] = f;
  endtask
  function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [OB-1:0] d, input logic [7:0] id);
    return {t, d, 19'd0, id};
  endfunction
  function automatic logic [FW-1:0] od(input int p);
    return bus.out_data[p*FW +: FW];
  endfunction
  function automatic logic [OB-1:0] op(input int p);
    return bus.out_port[p*OB +: OB];
  endfunction
  function automatic logic [OB-1:0] rp(input int p);
    return bus.req_ports[p*OB +: OB];
  endfunction
  initial begin
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.grants   = '0;
    repeat (2) tick;
    #1;
    check("rst_requests", bus.requests, 5'h00);
    check("rst_out_valid", bus.out_valid, 5'h00);
    check("rst_in_ready", bus.in_ready, 5'h1f);
    reset = 1'b1;
    // single flit, dest 3, on port 0
    tick; put(0, fl(2'b11, 3'd3, 8'h01)); #1;
    check("t1_in_ready", bus.in_ready[0], 1'b1);
    tick; clr; #1;
    check("t1_idle_req", bus.requests, 5'h00);
    tick; #1;
    check("t1_route_req", bus.requests, 5'h00);
    tick; #1;
    check("t1_req", bus.requests, 5'h01);
    check("t1_req_port", rp(0), 3'd3);
    tick; bus.grants = 5'h01; #1;
    check("t1_out_valid", bus.out_valid, 5'h01);
    check("t1_out_port", op(0), 3'd3);
    check("t1_out_data", od(0), fl(2'b11, 3'd3, 8'h01));
    check("t1_req_after_tail", bus.requests, 5'h00);
    tick; bus.grants = '0; #1;
    check("t1_out_valid_off", bus.out_valid, 5'h00);
    tick; tick; #1;
    check("t1_empty_req", bus.requests, 5'h00);
    check("t1_empty_ready", bus.in_ready, 5'h1f);
    // four-flit packet, dest 2, on port 1; grants whenever outstanding
    tick; put(1, fl(2'b10, 3'd2, 8'h10)); #1;
    tick; put(1, fl(2'b00, 3'd0, 8'h11)); #1;
    tick; put(1, fl(2'b00, 3'd0, 8'h12)); #1;
    tick; clr; #1;
    check("t2_req", bus.requests[1], 1'b1);
    check("t2_req_port", rp(1), 3'd2);
    tick; put(1, fl(2'b01, 3'd0, 8'h13)); bus.grants = 5'h02; #1;
    check("t2_head", od(1), fl(2'b10, 3'd2, 8'h10));
    check("t2_head_port", op(1), 3'd2);
    check("t2_req_c4", bus.requests[1], 1'b1);
    check("t2_ready_c4", bus.in_ready[1], 1'b1);
    tick; clr; #1;
    check("t2_body1", od(1), fl(2'b00, 3'd0, 8'h11));
    check("t2_req_c5", bus.requests[1], 1'b1);
    tick; #1;
    check("t2_body2", od(1), fl(2'b00, 3'd0, 8'h12));
    check("t2_req_c6", bus.requests[1], 1'b1);
    tick; #1;
    check("t2_tail", od(1), fl(2'b01, 3'd0, 8'h13));
    check("t2_no_req_past_tail", bus.requests[1], 1'b0);
    check("t2_ready_c7", bus.in_ready[1], 1'b1);
    tick; #1;
    check("t2_stray_grant", bus.out_valid[1], 1'b0);
    check("t2_idle_req", bus.requests[1], 1'b0);
    // fill port 2 to depth with no grants, then drain
    tick; bus.grants = '0; put(2, fl(2'b10, 3'd4, 8'h20)); #1;
    tick; put(2, fl(2'b00, 3'd0, 8'h21)); #1;
    tick; put(2, fl(2'b00, 3'd0, 8'h22)); #1;
    tick; put(2, fl(2'b00, 3'd0, 8'h23)); #1;
    check("t3_ready_c3", bus.in_ready[2], 1'b1);
    check("t3_req_c3", bus.requests[2], 1'b1);
    tick; put(2, fl(2'b01, 3'd0, 8'h2f)); bus.grants = 5'h04; #1;
    check("t3_full", bus.in_ready[2], 1'b0);
    check("t3_head", od(2), fl(2'b10, 3'd4, 8'h20));
    check("t3_head_port", op(2), 3'd4);
    tick; clr; #1;
    check("t3_ready_again", bus.in_ready[2], 1'b1);
    check("t3_body1", od(2), fl(2'b00, 3'd0, 8'h21));
    tick; #1;
    check("t3_body2", od(2), fl(2'b00, 3'd0, 8'h22));
    tick; #1;
    check("t3_body3", od(2), fl(2'b00, 3'd0, 8'h23));
    check("t3_no_extra_req", bus.requests[2], 1'b0);
    tick; bus.grants = '0; #1;
    check("t3_empty_req", bus.requests[2], 1'b0);
    // ports 0 and 4 contend for dest 1; only port 0 granted first
    tick; put(0, fl(2'b11, 3'd1, 8'h40)); put(4, fl(2'b10, 3'd1, 8'h41)); #1;
    tick; clr; put(4, fl(2'b00, 3'd0, 8'h42)); #1;
    tick; clr; put(4, fl(2'b01, 3'd0, 8'h43)); #1;
    tick; clr; #1;
    check("t4_both_req", bus.requests & 5'h11, 5'h11);
    check("t4_rp0", rp(0), 3'd1);
    check("t4_rp4", rp(4), 3'd1);
    tick; bus.grants = 5'h01; #1;
    check("t4_only_p0", bus.out_valid, 5'h01);
    check("t4_op0", op(0), 3'd1);
    check("t4_p4_holds", bus.requests[4], 1'b1);
    check("t4_p4_port", rp(4), 3'd1);
    tick; bus.grants = '0; #1;
    check("t4_no_valid", bus.out_valid, 5'h00);
    check("t4_p4_still", bus.requests[4], 1'b1);
    tick; bus.grants = 5'h10; #1;
    check("t4_p4_head", od(4), fl(2'b10, 3'd1, 8'h41));
    tick; #1;
    check("t4_p4_body", od(4), fl(2'b00, 3'd0, 8'h42));
    tick; #1;
    check("t4_p4_tail", od(4), fl(2'b01, 3'd0, 8'h43));
    check("t4_p4_done", bus.requests[4], 1'b0);
    // body flit arriving while idle is dropped
    tick; bus.grants = '0; put(1, fl(2'b00, 3'd7, 8'h50)); #1;
    tick; put(1, fl(2'b11, 3'd6, 8'h51)); #1;
    tick; clr; #1;
    tick; #1;
    check("t6_route_req", bus.requests[1], 1'b0);
    tick; #1;
    check("t6_req", bus.requests[1], 1'b1);
    check("t6_req_port", rp(1), 3'd6);
    tick; bus.grants = 5'h02; #1;
    check("t6_data", od(1), fl(2'b11, 3'd6, 8'h51));
    // async reset mid-packet on port 3
    tick; bus.grants = '0; put(3, fl(2'b10, 3'd2, 8'h60)); #1;
    tick; put(3, fl(2'b00, 3'd0, 8'h61)); #1;
    tick; clr; #1;
    tick; #1;
    check("t5_req_before", bus.requests[3], 1'b1);
    bus.grants = 5'h08;
    reset = 1'b0;
    #1;
    check("t5_rst_req", bus.requests, 5'h00);
    check("t5_rst_valid", bus.out_valid, 5'h00);
    check("t5_rst_ready", bus.in_ready, 5'h1f);
    tick; reset = 1'b1; #1;
    tick; #1;
    check("t5_grant_ignored", bus.out_valid, 5'h00);
    check("t5_post_req", bus.requests, 5'h00);
    check("t5_post_ready", bus.in_ready, 5'h1f);
    tick; bus.grants = '0; put(3, fl(2'b11, 3'd5, 8'h62)); #1;
    tick; clr; #1;
    tick; #1;
    tick; #1;
    check("t5_fresh_req", bus.requests[3], 1'b1);
    check("t5_fresh_port", rp(3), 3'd5);
    tick; bus.grants = 5'h08; #1;
    check("t5_fresh_data", od(3), fl(2'b11, 3'd5, 8'h62));
    tick; bus.grants = '0; #1;
`ifdef REQ_STARVE_CNT_EN
    tick; put(0, fl(2'b10, 3'd0, 8'h70)); #1;
    tick; put(0, fl(2'b00, 3'd0, 8'h71)); #1;
    tick; put(0, fl(2'b01, 3'd0, 8'h72)); #1;
    tick; clr; #1;
    repeat (254) tick;
    #1;
    check("t7_not_yet", bus.starve[0], 1'b0);
    tick; #1;
    check("t7_starve", bus.starve[0], 1'b1);
    tick; bus.grants = 5'h01; #1;
    check("t7_starve_held", bus.starve[0], 1'b1);
    tick; bus.grants = '0; #1;
    check("t7_cleared", bus.starve[0], 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
